// File: rtl/mem8x8_pkg.sv
// Shared widths, FSM state encoding and address helper for the mem8x8 read controller.
package mem8x8_pkg;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 8;
   localparam int LEN_W  = 3;
   localparam int CNT_W  = 3;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SAMPLE,
      RESP
   } state_e;

   // Rows wrap 7 -> 0 inside a burst; the natural ADDR_W-bit overflow does this.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
      return addr + 1'b1;
   endfunction

endpackage

// File: rtl/mem8x8_rsp_reg.sv
// Response holding register: captures the sampled row word and its tags, holds them through RESP.
// Optional parity capture is enabled with MEM_READ_PARITY_EN.
module mem8x8_rsp_reg
   import mem8x8_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              last_i,
`ifdef MEM_READ_PARITY_EN
   input  logic              perr_i,
   output logic              perr_o,
`endif
   output logic [DATA_W-1:0] data_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o
);

   logic [DATA_W-1:0] data_q;
   logic [ADDR_W-1:0] addr_q;
   logic              last_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         addr_q <= '0;
         last_q <= 1'b0;
      end else if (load_i) begin
         data_q <= data_i;
         addr_q <= addr_i;
         last_q <= last_i;
      end
   end

`ifdef MEM_READ_PARITY_EN
   logic perr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perr_q <= 1'b0;
      end else if (load_i) begin
         perr_q <= perr_i;
      end
   end

   assign perr_o = perr_q;
`endif

   assign data_o = data_q;
   assign addr_o = addr_q;
   assign last_o = last_q;

endmodule

// File: rtl/mem8x8_read_ctrl.sv
// Read-side controller for the 8x8 latch memory: single/burst reads with a programmable settle time.
// Define MEM_READ_PARITY_EN to add mem_par input and rsp_perr output.
module mem8x8_read_ctrl
   import mem8x8_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_q,
`ifdef MEM_READ_PARITY_EN
   input  logic              mem_par,
   output logic              rsp_perr,
`endif
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_last
);

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ready_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         cnt_q       <= '0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         cnt_q       <= cnt_d;
         ready_q     <= (state_d == IDLE);
      end
   end

   // ready_q tracks "next state is IDLE" so req_ready is registered and stays low during reset.
   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      cnt_d       = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid && ready_q) begin
               cur_addr_d  = req_addr;
               remaining_d = req_len;
               cnt_d       = '0;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SAMPLE: begin
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               if (remaining_q == '0) begin
                  state_d = IDLE;
               end else begin
                  remaining_d = remaining_q - 1'b1;
                  cur_addr_d  = next_addr(cur_addr_q);
                  cnt_d       = '0;
                  state_d     = SETUP;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready = ready_q;
   assign mem_addr  = cur_addr_q;
   assign mem_re    = (state_q == SETUP) || (state_q == SAMPLE);
   assign rsp_valid = (state_q == RESP);

   mem8x8_rsp_reg u_rsp_reg (
      .clk    (clk),
      .rst    (rst),
      .load_i (state_q == SAMPLE),
      .data_i (mem_q),
      .addr_i (cur_addr_q),
      .last_i (remaining_q == '0),
`ifdef MEM_READ_PARITY_EN
      .perr_i (^{mem_q, mem_par}),
      .perr_o (rsp_perr),
`endif
      .data_o (rsp_data),
      .addr_o (rsp_addr),
      .last_o (rsp_last)
   );

endmodule

// File: tb/tb_mem8x8_read_ctrl.sv
// Directed self-checking bench for mem8x8_read_ctrl: one instance at SETTLE_CYCLES=1, one at 4.
module tb_mem8x8_read_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] mem [8];

   logic       reqValid, reqReady, memRe, rspValid, rspReady, rspLast;
   logic [2:0] reqAddr, reqLen, memAddr, rspAddr;
   logic [7:0] memQ, rspData;

   logic       reqValid4, reqReady4, memRe4, rspValid4, rspReady4, rspLast4;
   logic [2:0] reqAddr4, reqLen4, memAddr4, rspAddr4;
   logic [7:0] memQ4, rspData4;

`ifdef MEM_READ_PARITY_EN
   logic memPar = 1'b0;
   logic rspPerr, rspPerr4;
`endif

   int passCount  = 0;
   int totalCount = 0;
   int reCount;

   always #5 clk = ~clk;

   assign memQ  = mem[memAddr];
   assign memQ4 = mem[memAddr4];

   mem8x8_read_ctrl #(.SETTLE_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(reqValid), .req_ready(reqReady), .req_addr(reqAddr), .req_len(reqLen),
      .mem_addr(memAddr), .mem_re(memRe), .mem_q(memQ),
`ifdef MEM_READ_PARITY_EN
      .mem_par(memPar), .rsp_perr(rspPerr),
`endif
      .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_data(rspData),
      .rsp_addr(rspAddr), .rsp_last(rspLast)
   );

   mem8x8_read_ctrl #(.SETTLE_CYCLES(4)) dut4 (
      .clk(clk), .rst(rst),
      .req_valid(reqValid4), .req_ready(reqReady4), .req_addr(reqAddr4), .req_len(reqLen4),
      .mem_addr(memAddr4), .mem_re(memRe4), .mem_q(memQ4),
`ifdef MEM_READ_PARITY_EN
      .mem_par(memPar), .rsp_perr(rspPerr4),
`endif
      .rsp_valid(rspValid4), .rsp_ready(rspReady4), .rsp_data(rspData4),
      .rsp_addr(rspAddr4), .rsp_last(rspLast4)
   );

   // Advance one cycle and settle 1 time unit past the rising edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      totalCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   initial begin
      reqValid  = 1'b0; reqAddr  = '0; reqLen  = '0; rspReady  = 1'b0;
      reqValid4 = 1'b0; reqAddr4 = '0; reqLen4 = '0; rspReady4 = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;

      // Reset state
      applyStimulus();
      applyStimulus();
      checkOutput("rst req_ready", reqReady, 0);
      checkOutput("rst mem_re", memRe, 0);
      checkOutput("rst mem_addr", memAddr, 0);
      checkOutput("rst rsp_valid", rspValid, 0);
      checkOutput("rst rsp_data", rspData, 0);
      checkOutput("rst rsp_addr", rspAddr, 0);
      checkOutput("rst rsp_last", rspLast, 0);
      checkOutput("rst req_ready4", reqReady4, 0);
      rst = 1'b0;
      applyStimulus();
      checkOutput("post-rst req_ready", reqReady, 1);
      checkOutput("post-rst req_ready4", reqReady4, 1);

      // Single read of row 3
      $display("[TB] single read");
      mem[3] = 8'hA5;
      reqValid = 1'b1; reqAddr = 3'd3; reqLen = 3'd0; rspReady = 1'b1;
      applyStimulus();
      reqValid = 1'b0;
      checkOutput("single c1 req_ready", reqReady, 0);
      checkOutput("single c1 mem_re", memRe, 1);
      checkOutput("single c1 mem_addr", memAddr, 3);
      checkOutput("single c1 rsp_valid", rspValid, 0);
      applyStimulus();
      checkOutput("single c2 mem_re", memRe, 1);
      checkOutput("single c2 rsp_valid", rspValid, 0);
      applyStimulus();
      checkOutput("single c3 rsp_valid", rspValid, 1);
      checkOutput("single c3 rsp_data", rspData, 8'hA5);
      checkOutput("single c3 rsp_addr", rspAddr, 3);
      checkOutput("single c3 rsp_last", rspLast, 1);
      checkOutput("single c3 mem_re", memRe, 0);
      applyStimulus();
      checkOutput("single c4 rsp_valid", rspValid, 0);
      checkOutput("single c4 req_ready", reqReady, 1);

      // Burst with wrap: rows 6,7,0,1
      $display("[TB] burst wrap");
      mem[6] = 8'h11; mem[7] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
      reqValid = 1'b1; reqAddr = 3'd6; reqLen = 3'd3;
      applyStimulus();
      reqValid = 1'b0;
      begin
         logic [7:0] expData [4];
         logic [2:0] expAddr [4];
         expData = '{8'h11, 8'h22, 8'h33, 8'h44};
         expAddr = '{3'd6, 3'd7, 3'd0, 3'd1};
         for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("burst w%0d setup mem_addr", k), memAddr, expAddr[k]);
            applyStimulus();
            checkOutput($sformatf("burst w%0d sample rsp_valid", k), rspValid, 0);
            applyStimulus();
            checkOutput($sformatf("burst w%0d rsp_valid", k), rspValid, 1);
            checkOutput($sformatf("burst w%0d rsp_data", k), rspData, expData[k]);
            checkOutput($sformatf("burst w%0d rsp_addr", k), rspAddr, expAddr[k]);
            checkOutput($sformatf("burst w%0d rsp_last", k), rspLast, (k == 3) ? 8'd1 : 8'd0);
            applyStimulus();
         end
      end
      checkOutput("burst end req_ready", reqReady, 1);
      checkOutput("burst end rsp_valid", rspValid, 0);

      // Backpressure: rsp_ready low for 5 RESP cycles
      $display("[TB] backpressure");
      mem[5] = 8'h5C;
      rspReady = 1'b0;
      reqValid = 1'b1; reqAddr = 3'd5; reqLen = 3'd0;
      applyStimulus();
      reqValid = 1'b0;
      applyStimulus();
      applyStimulus();
      for (int c = 0; c < 5; c++) begin
         checkOutput($sformatf("bp%0d rsp_valid", c), rspValid, 1);
         checkOutput($sformatf("bp%0d rsp_data", c), rspData, 8'h5C);
         checkOutput($sformatf("bp%0d mem_re", c), memRe, 0);
         checkOutput($sformatf("bp%0d req_ready", c), reqReady, 0);
         applyStimulus();
      end
      rspReady = 1'b1;
      #1;
      checkOutput("bp release rsp_valid", rspValid, 1);
      applyStimulus();
      checkOutput("bp done rsp_valid", rspValid, 0);
      checkOutput("bp done req_ready", reqReady, 1);

      // SETTLE_CYCLES=4 instance: mem_re high 5 cycles, rsp_valid in cycle 6
      $display("[TB] settle 4");
      mem[2] = 8'h3C;
      reqValid4 = 1'b1; reqAddr4 = 3'd2; reqLen4 = 3'd0; rspReady4 = 1'b1;
      applyStimulus();
      reqValid4 = 1'b0;
      reCount = 0;
      for (int c = 1; c <= 6; c++) begin
         if (memRe4) begin
            reCount++;
            checkOutput($sformatf("s4 c%0d mem_addr", c), memAddr4, 2);
         end
         checkOutput($sformatf("s4 c%0d rsp_valid", c), rspValid4, (c == 6) ? 8'd1 : 8'd0);
         if (c < 6) applyStimulus();
      end
      checkOutput("s4 mem_re cycles", 8'(reCount), 5);
      checkOutput("s4 rsp_data", rspData4, 8'h3C);
      applyStimulus();
      checkOutput("s4 done req_ready", reqReady4, 1);

`ifdef MEM_READ_PARITY_EN
      // Parity: 0x07 has odd weight, so mem_par=0 flags an error
      $display("[TB] parity");
      memPar = 1'b0;
      reqValid = 1'b1; reqAddr = 3'd2; reqLen = 3'd0;
      applyStimulus();
      reqValid = 1'b0;
      mem[2] = 8'h07;
      applyStimulus();
      applyStimulus();
      checkOutput("par0 rsp_data", rspData, 8'h07);
      checkOutput("par0 rsp_perr", rspPerr, 1);
      applyStimulus();
      memPar = 1'b1;
      reqValid = 1'b1;
      applyStimulus();
      reqValid = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("par1 rsp_perr", rspPerr, 0);
      applyStimulus();
`endif

      // Reset during SETUP of word 2 of an 8-word burst
      $display("[TB] reset mid-burst");
      for (int i = 0; i < 8; i++) mem[i] = 8'(8'hC0 + i);
      reqValid = 1'b1; reqAddr = 3'd0; reqLen = 3'd7;
      applyStimulus();
      reqValid = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("mid w1 rsp_data", rspData, 8'hC0);
      applyStimulus();
      checkOutput("mid w2 setup mem_re", memRe, 1);
      checkOutput("mid w2 setup mem_addr", memAddr, 1);
      rst = 1'b1;
      #1;
      checkOutput("mid rst mem_re", memRe, 0);
      checkOutput("mid rst mem_addr", memAddr, 0);
      checkOutput("mid rst req_ready", reqReady, 0);
      checkOutput("mid rst rsp_valid", rspValid, 0);
      checkOutput("mid rst rsp_data", rspData, 0);
      checkOutput("mid rst rsp_addr", rspAddr, 0);
      checkOutput("mid rst rsp_last", rspLast, 0);
      applyStimulus();
      rst = 1'b0;
      applyStimulus();
      checkOutput("mid post req_ready", reqReady, 1);
      begin
         int strayValid = 0;
         int strayRe = 0;
         for (int c = 0; c < 12; c++) begin
            if (rspValid) strayValid++;
            if (memRe) strayRe++;
            applyStimulus();
         end
         checkOutput("mid post rsp_valid count", 8'(strayValid), 0);
         checkOutput("mid post mem_re count", 8'(strayRe), 0);
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule

// File: doc/mem8x8_read_ctrl.md
# mem8x8_read_ctrl

Read-side controller for the 8x8 latch memory: accepts single or burst read requests, drives the row address and read enable into the array, waits a configurable settle time, captures the 8-bit word and presents it on a valid/ready response port. It is the read counterpart to the array's existing data/we write path and sits between the bus interface and the mem8x8 storage array.

## Interface
- SETTLE_CYCLES, 1, cycles mem_re is held with a stable mem_addr before sampling (legal 1..7)
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  read request present
- req_ready  output  1  controller can accept a request (high only in IDLE)
- req_addr  input  3  start row
- req_len  input  3  burst length minus one (0 = 1 word, 7 = 8 words)
- mem_addr  output  3  row select to array
- mem_re  output  1  row read enable to array
- mem_q  input  8  row data from array
- rsp_valid  output  1  rsp_data valid
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  8  captured word
- rsp_addr  output  3  row the word came from
- rsp_last  output  1  final word of burst

## Operation
- States: IDLE, SETUP, SAMPLE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready latch req_addr into cur_addr, req_len into remaining; go SETUP.
- SETUP: mem_addr=cur_addr, mem_re=1, settle counter counts SETTLE_CYCLES cycles; then SAMPLE.
- SAMPLE: mem_re=1, mem_addr unchanged; at end of cycle rsp_data<=mem_q, rsp_addr<=cur_addr, rsp_last<=(remaining==0); go RESP.
- RESP: rsp_valid=1, mem_re=0, rsp_* held stable until rsp_ready. On rsp_valid&&rsp_ready: if remaining==0 go IDLE, else remaining-=1, cur_addr+=1 modulo 8, go SETUP.
- Address wrap: row 7 -> row 0 within a burst (e.g. addr 6, len 3 reads 6,7,0,1).
- mem_addr holds last value when mem_re=0; array ignores it.
- Requests arriving outside IDLE are not accepted (req_ready=0); requester must hold them.

## Timing
- Reset values: req_ready=0 while rst high, 1 first cycle after release; mem_re=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_last=0; state IDLE.
- Latency: handshake in cycle 0 -> SETUP cycles 1..S -> SAMPLE cycle S+1 -> rsp_valid high cycle S+2 (S=SETTLE_CYCLES; 3 cycles at default).
- Burst word spacing with rsp_ready held high: S+2 cycles per word.
- rsp_ready high in the cycle rsp_valid rises completes the transfer that cycle.
- No combinational path from any input to any output except none; all outputs registered or decoded from state.
- Reset asserted mid-burst: immediate return to IDLE, all outputs to reset values, remaining words dropped, no partial response.

## Configuration
- MEM_READ_PARITY_EN defined: adds input mem_par (1 bit, even parity stored with each row) and output rsp_perr (1 bit, reset 0), registered in SAMPLE as ^{mem_q,mem_par} and held with rsp_data; errors do not abort bursts.
- Undefined: ports mem_par and rsp_perr absent; no parity logic.

## Structure
- mem8x8_pkg: ADDR_W=3, DATA_W=8, LEN_W=3, state enum (IDLE, SETUP, SAMPLE, RESP).
- Sub-module mem8x8_rsp_reg: response holding register (rsp_data, rsp_addr, rsp_last, optional rsp_perr) with load enable from SAMPLE; FSM and settle counter stay in top.

## Test plan
- Single read, array row 3=0xA5, req_addr=3, req_len=0, rsp_ready=1 -> rsp_valid in cycle 3, rsp_data=0xA5, rsp_addr=3, rsp_last=1, back to IDLE cycle 4.
- Burst wrap, rows 6,7,0,1 = 0x11,0x22,0x33,0x44, req_addr=6, req_len=3 -> four responses in that order, rsp_last only on 0x44, spacing 3 cycles.
- Backpressure, rsp_ready low 5 cycles during RESP -> rsp_valid/rsp_data stable, mem_re=0, req_ready=0 throughout; resumes on rsp_ready.
- SETTLE_CYCLES=4, single read -> mem_re high exactly 5 cycles with constant mem_addr, rsp_valid in cycle 6.
- Reset asserted during SETUP of word 2 of an 8-word burst -> all outputs 0 immediately, req_ready=1 after release, no further responses.
- MEM_READ_PARITY_EN, row 2=0x07 with mem_par=0 -> rsp_perr=1; mem_par=1 -> rsp_perr=0.
